// File: rtl/divider_iterative.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Handshake: single-cycle valid_in start pulse, single-cycle valid_out result pulse.
module divider_iterative #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid_out,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dbz
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] dvd, dvd_n;
   logic [WIDTH-1:0] dvs, dvs_n;
   logic [WIDTH-1:0] rem, rem_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] q_n, r_n;
   logic             dbz_n, busy_n, valid_out_n;
   logic [WIDTH:0]   rem_sh, rem_diff;
   logic             geq;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         q         <= '0;
         r         <= '0;
         dbz       <= 1'b0;
         busy      <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_n;
         dvd       <= dvd_n;
         dvs       <= dvs_n;
         rem       <= rem_n;
         cnt       <= cnt_n;
         q         <= q_n;
         r         <= r_n;
         dbz       <= dbz_n;
         busy      <= busy_n;
         valid_out <= valid_out_n;
      end
   end

   // Next-state, iteration step and result load
   always_comb begin
      state_n = state;
      dvd_n   = dvd;
      dvs_n   = dvs;
      rem_n   = rem;
      cnt_n   = cnt;
      q_n     = q;
      r_n     = r;
      dbz_n   = dbz;

      // Widened by one bit so the shifted remainder never loses its top bit
      rem_sh   = {rem, dvd[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dvs};
      geq      = ~rem_diff[WIDTH];

      case (state)
         RUN: begin
            dvd_n = {dvd[WIDTH-2:0], geq};
            rem_n = geq ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               state_n = DONE;
               q_n     = dvd_n;
               r_n     = rem_n;
               dbz_n   = 1'b0;
            end
         end
         IDLE, DONE: begin
            state_n = IDLE;
            if (valid_in) begin
               dvd_n = a;
               dvs_n = b;
               rem_n = '0;
               cnt_n = '0;
               if (b == '0) begin
                  state_n = DONE;
                  q_n     = '1;
                  r_n     = a;
                  dbz_n   = 1'b1;
               end else begin
                  state_n = RUN;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n      = (state_n == RUN);
      valid_out_n = (state_n == DONE);
   end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed cases, mid-run reset
// and an incrementing/random operand sweep against plain-arithmetic division.
module tb_divider_iterative;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             valid_in;
   logic [WIDTH-1:0] a, b;
   logic             valid_out, busy, dbz;
   logic [WIDTH-1:0] q, r;

   int n_checks = 0;
   int n_fail   = 0;

   divider_iterative #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .a        (a),
      .b        (b),
      .valid_out(valid_out),
      .busy     (busy),
      .q        (q),
      .r        (r),
      .dbz      (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: what an unsigned divide of a by b must return
   task automatic ref_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          output logic [WIDTH-1:0] eq, output logic [WIDTH-1:0] er,
                          output logic ed, output int elat);
      if (y == 0) begin
         eq = {WIDTH{1'b1}}; er = x; ed = 1'b1; elat = 0;
      end else begin
         eq = x / y; er = x % y; ed = 1'b0; elat = WIDTH;
      end
   endtask

   // Drive a one-cycle start pulse; returns at the negedge after the accept edge
   task automatic start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      valid_in = 1'b1; a = x; b = y;
      @(negedge clk);
      valid_in = 1'b0;
      a = $urandom; b = $urandom;
   endtask

   // Counts edges since accept until valid_out, bounded
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0; busy_cnt = 0;
      while (!valid_out && lat < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] eq, er;
      logic ed;
      int elat, lat, bc;
      ref_div(x, y, eq, er, ed, elat);
      start(x, y);
      wait_done(lat, bc);
      check({tag, ".lat"}, 64'(lat), 64'(elat));
      check({tag, ".busy"}, 64'(bc), 64'(elat));
      check({tag, ".q"}, 64'(q), 64'(eq));
      check({tag, ".r"}, 64'(r), 64'(er));
      check({tag, ".dbz"}, 64'(dbz), 64'(ed));
      @(negedge clk);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb, eq, er;
      logic ed;
      int elat, lat, bc, lat2;

      rst_n = 1'b0; valid_in = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst.valid_out", 64'(valid_out), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.q", 64'(q), 64'd0);
      check("rst.r", 64'(r), 64'd0);
      check("rst.dbz", 64'(dbz), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First op, plus one-cycle valid_out pulse
      start(32'd100, 32'd7);
      wait_done(lat, bc);
      check("t1.lat", 64'(lat), 64'd32);
      check("t1.busy", 64'(bc), 64'd32);
      check("t1.q", 64'(q), 64'd14);
      check("t1.r", 64'(r), 64'd2);
      check("t1.dbz", 64'(dbz), 64'd0);
      @(negedge clk);
      check("t1.pulse", 64'(valid_out), 64'd0);
      check("t1.hold_q", 64'(q), 64'd14);

      run_op("max_by_1", 32'hFFFF_FFFF, 32'd1);
      run_op("small", 32'd3, 32'd10);
      run_op("msb", 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("wide_rem", 32'hFFFF_FFFF, 32'h8000_0001);
      run_op("dbz", 32'd5, 32'd0);
      run_op("after_dbz", 32'd9, 32'd3);

      // valid_in during RUN is ignored
      start(32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      valid_in = 1'b1; a = 32'd50; b = 32'd5;
      @(negedge clk);
      valid_in = 1'b0;
      wait_done(lat, bc);
      check("ign.lat", 64'(lat + 10), 64'd32);
      check("ign.q", 64'(q), 64'd333);
      check("ign.r", 64'(r), 64'd1);

      // Back-to-back accept while DONE
      start(32'd50, 32'd5);
      check("b2b.busy", 64'(busy), 64'd1);
      check("b2b.hold_q", 64'(q), 64'd333);
      wait_done(lat, bc);
      check("b2b.lat", 64'(lat), 64'd32);
      check("b2b.q", 64'(q), 64'd10);
      check("b2b.r", 64'(r), 64'd0);
      @(negedge clk);

      // Reset mid-RUN
      start(32'd12345, 32'd17);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst.busy", 64'(busy), 64'd0);
      check("mid_rst.valid_out", 64'(valid_out), 64'd0);
      check("mid_rst.q", 64'(q), 64'd0);
      check("mid_rst.r", 64'(r), 64'd0);
      check("mid_rst.dbz", 64'(dbz), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bc = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid_out || busy) bc++;
      end
      check("mid_rst.quiet", 64'(bc), 64'd0);
      run_op("post_rst", 32'd77, 32'd8);

      // Incrementing operand sweep
      ra = $urandom; rb = $urandom;
      for (int i = 0; i < 200; i++) begin
         ra = ra + 32'h2345_6789;
         rb = rb + 32'h3456_7891;
         if (i % 8 == 3) rb = rb >> $urandom_range(31, 1);
         ref_div(ra, rb, eq, er, ed, elat);
         start(ra, rb);
         wait_done(lat, bc);
         lat2 = n_fail;
         check("sw.lat", 64'(lat), 64'(elat));
         check("sw.q", 64'(q), 64'(eq));
         check("sw.r", 64'(r), 64'(er));
         check("sw.dbz", 64'(dbz), 64'(ed));
         if (!ed) begin
            check("sw.inv", 64'(q) * 64'(rb) + 64'(r), 64'(ra));
            check("sw.r_lt_b", 64'(r < rb), 64'd1);
         end
         if (n_fail != lat2) begin
            $display("FAIL sweep: op %0d a=0x%0h b=0x%0h", i, ra, rb);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "sweep mismatch");
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
